// File: rtl/alarm_clock_controller.sv
// Alarm clock timekeeping and alarm sequencer: BCD time/alarm registers,
// a button-driven set-mode FSM and a ring/snooze/auto-stop alarm FSM.
module alarm_clock_controller #(
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_MAX_MIN = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_alarm,
    output logic [7:0] disp_hours,
    output logic [7:0] disp_minutes,
    output logic [7:0] disp_seconds,
    output logic [2:0] mode,
    output logic       alarm_armed,
    output logic       buzzer
);

    localparam logic [2:0] MODE_RUN         = 3'd0;
    localparam logic [2:0] MODE_SET_HR      = 3'd1;
    localparam logic [2:0] MODE_SET_MIN     = 3'd2;
    localparam logic [2:0] MODE_SET_ALM_HR  = 3'd3;
    localparam logic [2:0] MODE_SET_ALM_MIN = 3'd4;

    localparam logic [1:0] AL_IDLE    = 2'd0;
    localparam logic [1:0] AL_RINGING = 2'd1;
    localparam logic [1:0] AL_SNOOZE  = 2'd2;

    localparam logic [3:0] SNOOZE_LOAD = 4'(SNOOZE_MIN);
    localparam logic [3:0] RING_LIMIT  = 4'(RING_MAX_MIN);

    // Increment a two-digit BCD value, wrapping to 00 after max_val.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
        logic [7:0] res;
        if (val == max_val)
            res = 8'h00;
        else if (val[3:0] == 4'd9)
            res = {val[7:4] + 4'd1, 4'd0};
        else
            res = {val[7:4], val[3:0] + 4'd1};
        return res;
    endfunction

    function automatic logic [2:0] mode_next(input logic [2:0] cur);
        logic [2:0] nxt;
        case (cur)
            MODE_RUN:        nxt = MODE_SET_HR;
            MODE_SET_HR:     nxt = MODE_SET_MIN;
            MODE_SET_MIN:    nxt = MODE_SET_ALM_HR;
            MODE_SET_ALM_HR: nxt = MODE_SET_ALM_MIN;
            default:         nxt = MODE_RUN;
        endcase
        return nxt;
    endfunction

    logic [7:0] hr_q, hr_d, min_q, min_d, sec_q, sec_d;
    logic [7:0] alm_hr_q, alm_hr_d, alm_min_q, alm_min_d;
    logic [2:0] mode_q, mode_d;
    logic       armed_q, armed_d;
    logic [1:0] al_state_q, al_state_d;
    logic [3:0] snooze_cnt_q, snooze_cnt_d;
    logic [3:0] ring_cnt_q, ring_cnt_d;
    logic       match_q, match_d;

    logic do_alarm, do_mode, do_inc;
    logic time_run, time_tick, minute_roll;

    // Only the highest-priority button pulse of a cycle acts.
    assign do_alarm = btn_alarm;
    assign do_mode  = btn_mode & ~btn_alarm;
    assign do_inc   = btn_inc & ~btn_mode & ~btn_alarm;

    assign time_run  = (mode_q != MODE_SET_HR) && (mode_q != MODE_SET_MIN);
    assign time_tick = time_run & tick_1hz;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hr_d         = hr_q;
        min_d        = min_q;
        sec_d        = sec_q;
        alm_hr_d     = alm_hr_q;
        alm_min_d    = alm_min_q;
        mode_d       = mode_q;
        armed_d      = armed_q;
        al_state_d   = al_state_q;
        snooze_cnt_d = snooze_cnt_q;
        ring_cnt_d   = ring_cnt_q;
        minute_roll  = 1'b0;

        if (time_tick) begin
            sec_d = bcd_inc(sec_q, 8'h59);
            if (sec_q == 8'h59) begin
                minute_roll = 1'b1;
                min_d       = bcd_inc(min_q, 8'h59);
                if (min_q == 8'h59)
                    hr_d = bcd_inc(hr_q, 8'h23);
            end
        end

        // Set-mode increments never carry; ticks cannot collide with them in SET_HR/SET_MIN.
        if (do_inc) begin
            case (mode_q)
                MODE_SET_HR:      hr_d      = bcd_inc(hr_q, 8'h23);
                MODE_SET_MIN:     min_d     = bcd_inc(min_q, 8'h59);
                MODE_SET_ALM_HR:  alm_hr_d  = bcd_inc(alm_hr_q, 8'h23);
                MODE_SET_ALM_MIN: alm_min_d = bcd_inc(alm_min_q, 8'h59);
                default: ;
            endcase
        end

        if (do_mode && (al_state_q == AL_IDLE)) begin
            mode_d = mode_next(mode_q);
            if (mode_q == MODE_SET_MIN)
                sec_d = 8'h00;
        end

        // Registered so the buzzer rises one cycle after the time shows the match.
        match_d = time_tick && (mode_q == MODE_RUN) && armed_q &&
                  (hr_d == alm_hr_q) && (min_d == alm_min_q) && (sec_d == 8'h00);

        case (al_state_q)
            AL_IDLE: begin
                if (do_alarm) begin
                    armed_d = ~armed_q;
                end else if (match_q) begin
                    al_state_d = AL_RINGING;
                    ring_cnt_d = 4'd0;
                end
            end
            AL_RINGING: begin
                if (do_alarm) begin
                    al_state_d = AL_IDLE;
                    ring_cnt_d = 4'd0;
                end else if (do_inc) begin
                    al_state_d   = AL_SNOOZE;
                    snooze_cnt_d = SNOOZE_LOAD;
                    ring_cnt_d   = 4'd0;
                end else if (minute_roll) begin
                    if (ring_cnt_q + 4'd1 == RING_LIMIT) begin
                        al_state_d = AL_IDLE;
                        ring_cnt_d = 4'd0;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 4'd1;
                    end
                end
            end
            AL_SNOOZE: begin
                if (do_alarm) begin
                    al_state_d   = AL_IDLE;
                    snooze_cnt_d = 4'd0;
                end else if (minute_roll) begin
                    if (snooze_cnt_q <= 4'd1) begin
                        al_state_d   = AL_RINGING;
                        snooze_cnt_d = 4'd0;
                        ring_cnt_d   = 4'd0;
                    end else begin
                        snooze_cnt_d = snooze_cnt_q - 4'd1;
                    end
                end
            end
            default: al_state_d = AL_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_q         <= 8'h00;
            min_q        <= 8'h00;
            sec_q        <= 8'h00;
            alm_hr_q     <= 8'h00;
            alm_min_q    <= 8'h00;
            mode_q       <= MODE_RUN;
            armed_q      <= 1'b0;
            al_state_q   <= AL_IDLE;
            snooze_cnt_q <= 4'd0;
            ring_cnt_q   <= 4'd0;
            match_q      <= 1'b0;
        end else if (ena) begin
            hr_q         <= hr_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            alm_hr_q     <= alm_hr_d;
            alm_min_q    <= alm_min_d;
            mode_q       <= mode_d;
            armed_q      <= armed_d;
            al_state_q   <= al_state_d;
            snooze_cnt_q <= snooze_cnt_d;
            ring_cnt_q   <= ring_cnt_d;
            match_q      <= match_d;
        end
    end

    logic show_alarm;
    assign show_alarm   = (mode_q == MODE_SET_ALM_HR) || (mode_q == MODE_SET_ALM_MIN);
    assign disp_hours   = show_alarm ? alm_hr_q  : hr_q;
    assign disp_minutes = show_alarm ? alm_min_q : min_q;
    assign disp_seconds = sec_q;
    assign mode         = mode_q;
    assign alarm_armed  = armed_q;
    assign buzzer       = (al_state_q == AL_RINGING);

endmodule

// File: tb/tb_alarm_clock_controller.sv
// Scoreboard bench for alarm_clock_controller: expectations are queued as
// stimulus is applied and compared against the outputs after each step.
module tb_alarm_clock_controller;

    logic       clk = 1'b0;
    logic       rst_n, ena, tick_1hz, btn_mode, btn_inc, btn_alarm;
    logic [7:0] disp_hours, disp_minutes, disp_seconds;
    logic [2:0] mode;
    logic       alarm_armed, buzzer;

    always #5 clk = ~clk;

    alarm_clock_controller #(
        .SNOOZE_MIN  (5),
        .RING_MAX_MIN(10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .tick_1hz    (tick_1hz),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .btn_alarm   (btn_alarm),
        .disp_hours  (disp_hours),
        .disp_minutes(disp_minutes),
        .disp_seconds(disp_seconds),
        .mode        (mode),
        .alarm_armed (alarm_armed),
        .buzzer      (buzzer)
    );

    typedef enum int {F_HR, F_MIN, F_SEC, F_MODE, F_ARM, F_BUZ} field_e;
    typedef struct {
        string      tag;
        field_e     fld;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] observe(input field_e f);
        case (f)
            F_HR:    return disp_hours;
            F_MIN:   return disp_minutes;
            F_SEC:   return disp_seconds;
            F_MODE:  return {5'd0, mode};
            F_ARM:   return {7'd0, alarm_armed};
            default: return {7'd0, buzzer};
        endcase
    endfunction

    task automatic push(input string tag, input field_e f, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.fld = f;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic push_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s);
        push({tag, ".hr"}, F_HR, h);
        push({tag, ".min"}, F_MIN, m);
        push({tag, ".sec"}, F_SEC, s);
    endtask

    task automatic drain;
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.fld), e.val);
        end
    endtask

    // One clock cycle with the given pulses; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic t, input logic m, input logic i, input logic a);
        @(negedge clk);
        tick_1hz  = t;
        btn_mode  = m;
        btn_inc   = i;
        btn_alarm = a;
        @(posedge clk);
        #1;
        tick_1hz  = 1'b0;
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;
        btn_alarm = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic presses_mode(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic presses_inc(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        tick_1hz  = 1'b0;
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;
        btn_alarm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_time("rst", 8'h00, 8'h00, 8'h00);
        push("rst.mode", F_MODE, 8'd0);
        push("rst.arm", F_ARM, 8'd0);
        push("rst.buz", F_BUZ, 8'd0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;

        // Set modes: hours to 13, minutes wrap past 59 to 01, ticks ignored.
        presses_mode(1);
        push("sethr.mode", F_MODE, 8'd1);
        presses_inc(13);
        push("sethr.hr", F_HR, 8'h13);
        ticks(3);
        push("sethr.sec", F_SEC, 8'h00);
        drain();
        presses_mode(1);
        presses_inc(61);
        ticks(1);
        push("setmin.mode", F_MODE, 8'd2);
        push_time("setmin", 8'h13, 8'h01, 8'h00);
        drain();

        // Build 23:59 and walk through the alarm modes back to RUN.
        presses_inc(58);
        push("min59", F_MIN, 8'h59);
        drain();
        presses_mode(1);
        push("almhr.mode", F_MODE, 8'd3);
        push("almhr.disp_hr", F_HR, 8'h00);
        push("almhr.disp_min", F_MIN, 8'h00);
        drain();
        presses_mode(2);
        push("run1.mode", F_MODE, 8'd0);
        push_time("run1", 8'h13, 8'h59, 8'h00);
        drain();
        presses_mode(1);
        presses_inc(10);
        presses_mode(4);
        push("run2.mode", F_MODE, 8'd0);
        push_time("run2", 8'h23, 8'h59, 8'h00);
        drain();

        // Rollover; alarm 00:00 matches here but is not armed.
        ticks(59);
        push_time("roll59", 8'h23, 8'h59, 8'h59);
        drain();
        ticks(1);
        push_time("roll00", 8'h00, 8'h00, 8'h00);
        drain();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        push("unarmed.buz", F_BUZ, 8'd0);
        drain();

        // Arm, set alarm 00:01 with a tick in the same cycle as the increment.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        push("arm.on", F_ARM, 8'd1);
        drain();
        presses_mode(4);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        push("almmin.mode", F_MODE, 8'd4);
        push_time("almmin", 8'h00, 8'h01, 8'h01);
        drain();
        presses_mode(1);
        push_time("run3", 8'h00, 8'h00, 8'h01);
        drain();
        ticks(58);
        push_time("pre", 8'h00, 8'h00, 8'h59);
        push("pre.buz", F_BUZ, 8'd0);
        drain();
        ticks(1);
        push_time("match", 8'h00, 8'h01, 8'h00);
        push("match.buz", F_BUZ, 8'd0);
        drain();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        push("ring.buz", F_BUZ, 8'd1);
        drain();
        presses_mode(1);
        push("ring.mode_ign", F_MODE, 8'd0);
        push("ring.buz2", F_BUZ, 8'd1);
        drain();

        // Snooze for five minute rolls.
        presses_inc(1);
        push("snz.buz", F_BUZ, 8'd0);
        drain();
        ticks(4 * 60);
        push("snz4.buz", F_BUZ, 8'd0);
        push_time("snz4", 8'h00, 8'h05, 8'h00);
        drain();
        ticks(60);
        push("snz5.buz", F_BUZ, 8'd1);
        push_time("snz5", 8'h00, 8'h06, 8'h00);
        drain();

        // Auto-stop after ten unattended minute rolls.
        ticks(9 * 60);
        push("auto9.buz", F_BUZ, 8'd1);
        drain();
        ticks(60);
        push("auto10.buz", F_BUZ, 8'd0);
        push("auto10.arm", F_ARM, 8'd1);
        push_time("auto10", 8'h00, 8'h16, 8'h00);
        drain();

        // Ring at 00:17 and stop it with btn_alarm.
        presses_mode(4);
        presses_inc(16);
        push("alm17", F_MIN, 8'h17);
        drain();
        presses_mode(1);
        ticks(60);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        push("ring2.buz", F_BUZ, 8'd1);
        drain();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        push("stop.buz", F_BUZ, 8'd0);
        push("stop.arm", F_ARM, 8'd1);
        drain();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        push("arm.off", F_ARM, 8'd0);
        drain();

        // Disarmed match at 00:18 must not ring.
        presses_mode(4);
        presses_inc(1);
        presses_mode(1);
        ticks(60);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        push("noarm.buz", F_BUZ, 8'd0);
        push_time("noarm", 8'h00, 8'h18, 8'h00);
        drain();

        // Priority: alarm beats mode, mode beats inc.
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        push("prio_am.arm", F_ARM, 8'd1);
        push("prio_am.mode", F_MODE, 8'd0);
        drain();
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        push("prio_mi.mode", F_MODE, 8'd2);
        push("prio_mi.hr", F_HR, 8'h00);
        push("prio_mi.min", F_MIN, 8'h18);
        drain();
        presses_mode(3);

        // Tick on the RUN->SET_HR edge still counts; SET_MIN->SET_ALM_HR clears it.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        push("tickmode.mode", F_MODE, 8'd1);
        push("tickmode.sec", F_SEC, 8'h01);
        drain();
        presses_mode(2);
        push("secclr", F_SEC, 8'h00);
        drain();
        presses_mode(2);

        // Freeze with ena low.
        ena = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        push_time("frz", 8'h00, 8'h18, 8'h00);
        push("frz.mode", F_MODE, 8'd0);
        push("frz.arm", F_ARM, 8'd1);
        drain();
        ena = 1'b1;

        // Ring at 00:19, then assert reset asynchronously between edges.
        presses_mode(4);
        presses_inc(1);
        presses_mode(1);
        ticks(60);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        push("ring3.buz", F_BUZ, 8'd1);
        drain();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push("arst.buz", F_BUZ, 8'd0);
        push("arst.arm", F_ARM, 8'd0);
        push("arst.mode", F_MODE, 8'd0);
        push_time("arst", 8'h00, 8'h00, 8'h00);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        presses_mode(3);
        push("arst.alm_hr", F_HR, 8'h00);
        push("arst.alm_min", F_MIN, 8'h00);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_clock_controller.md
Name: alarm_clock_controller

Overview:
Timekeeping and alarm sequencer for the digital alarm clock top level. It holds the BCD time and alarm registers and runs a mode FSM for setting time and alarm from three debounced button pulses. An alarm FSM handles ringing, snooze and auto-stop. The top level feeds it a 1 Hz strobe and drives the display mux and buzzer pin from its outputs.

Parameters:
SNOOZE_MIN, 5, minutes from snooze until the alarm rings again (1..15)
RING_MAX_MIN, 10, minutes of unattended ringing before auto-stop (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
ena  in  1  global enable; low freezes all state
tick_1hz  in  1  one-cycle pulse, once per second
btn_mode  in  1  one-cycle debounced pulse
btn_inc  in  1  one-cycle debounced pulse
btn_alarm  in  1  one-cycle debounced pulse
disp_hours  out  8  BCD hours 00-23 (time or alarm, per mode)
disp_minutes  out  8  BCD minutes 00-59 (time or alarm, per mode)
disp_seconds  out  8  BCD seconds of current time (always time)
mode  out  3  0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_ALM_HR, 4 SET_ALM_MIN
alarm_armed  out  1  alarm enabled flag
buzzer  out  1  high while alarm FSM is RINGING

Behaviour:
- Reset (async, rst_n low): time 00:00:00, alarm 00:00, mode RUN, alarm_armed 0, alarm FSM IDLE, buzzer 0, snooze and ring counters 0. All outputs are registered or decoded directly from registers.
- ena low: every register holds. Pulses arriving during that time are lost.
- Time arithmetic: BCD per digit. Seconds 59->00 carries to minutes. Minutes 59->00 carries to hours. Hours 23->00.
- Time registers update on the clk edge where tick_1hz=1, in modes RUN, SET_ALM_HR and SET_ALM_MIN. In SET_HR and SET_MIN the clock is paused and ticks are ignored.
- minute_roll: internal pulse generated on a tick edge where seconds go 59->00.
- Button priority when several pulses arrive in one cycle: btn_alarm > btn_mode > btn_inc. Only the highest-priority pulse acts.
- Mode FSM: btn_mode steps RUN->SET_HR->SET_MIN->SET_ALM_HR->SET_ALM_MIN->RUN.
- btn_mode is ignored unless the alarm FSM is IDLE.
- On the SET_MIN->SET_ALM_HR transition, seconds clear to 00.
- btn_inc in SET_HR: hours +1 mod 24. In SET_MIN: minutes +1 mod 60. No carry in either case, and seconds are unchanged.
- btn_inc in SET_ALM_HR / SET_ALM_MIN applies the same rules to the alarm registers.
- Display: disp_hours and disp_minutes show the alarm in modes 3 and 4, and the time otherwise.
- Alarm FSM states: IDLE, RINGING, SNOOZE.
- IDLE -> RINGING: when alarm_armed=1, mode=RUN, and a tick edge makes time equal to alarm_hh:alarm_mm:00. buzzer goes high on the next clk edge, one cycle after the time register shows the match. A match in any other mode is missed; there is no late trigger.
- RINGING: btn_inc -> SNOOZE, snooze counter loaded with SNOOZE_MIN, ring counter cleared.
- RINGING: btn_alarm -> IDLE; alarm_armed stays 1.
- RINGING: each minute_roll increments the ring counter. When it reaches RING_MAX_MIN the FSM goes to IDLE and the counter clears.
- SNOOZE: buzzer 0. Each minute_roll decrements the snooze counter. On the roll that makes it 0, the FSM goes to RINGING and the ring counter clears.
- SNOOZE: btn_alarm -> IDLE.
- In IDLE, btn_alarm toggles alarm_armed. In RINGING or SNOOZE, btn_alarm does not toggle it.
- A match occurring while the FSM is already RINGING or SNOOZE has no effect.
- btn_inc in RUN with the FSM in IDLE: no effect.
- tick_1hz and any button in the same cycle: both act. Ordering:
  - Mode is evaluated on its pre-edge value.
  - A btn_mode edge RUN->SET_HR still applies that cycle's tick, because the pre-edge mode is RUN.
  - btn_inc in a SET mode plus a tick: tick is ignored in SET_HR/SET_MIN; in alarm modes it updates time while the increment updates the alarm.

Test Plan:
- Time rollover: set 23:59 via SET_HR/SET_MIN, return to RUN, apply 59 ticks -> 23:59:59; one more tick -> 00:00:00, no carry glitch.
- Set modes: from reset, btn_mode, 13x btn_inc -> disp_hours=0x13; btn_mode, 61x btn_inc -> disp_minutes=0x01, hours still 0x13; ticks in SET_HR/SET_MIN leave seconds at 00.
- Trigger: alarm 00:01, armed, time 00:00:59 in RUN, tick -> time 00:01:00, buzzer=1 exactly one clk later. Repeat with alarm_armed=0 -> buzzer stays 0.
- Snooze: while ringing, btn_inc -> buzzer 0 next cycle; after 4 minute_rolls buzzer still 0; the 5th roll -> buzzer 1 (SNOOZE_MIN=5).
- Auto-stop and stop: ring untouched for 10 minute_rolls -> buzzer 0, alarm_armed=1. Ring again, btn_alarm -> buzzer 0, alarm_armed unchanged. btn_alarm in IDLE -> alarm_armed toggles.
- Priority and freeze: btn_alarm+btn_mode in the same cycle in RUN/IDLE -> alarm_armed toggles, mode stays 0. ena=0 with ticks/buttons -> no state change. rst_n low mid-ring -> buzzer 0 immediately (async), all registers at reset values.
